// File: rtl/prog_loader.sv
// prog_loader: streaming boot loader that fills NUM_CHANNELS BRAMs from a valid/ready word stream, then releases the CPU.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - one-cycle pulse beginning a load (honoured in IDLE/DONE/ERROR)
//   s_valid   - stream word valid
//   s_data    - stream word (per channel: header with count in [15:0], then payload)
//   s_ready   - loader accepts s_data this cycle (depends on state only)
//   w_addr    - BRAM byte address (word_idx*4)
//   w_dat     - BRAM write data, shared by all channels
//   w_enb     - one-hot per-channel write enable, single-cycle pulse per word
//   cpu_stall - holds the CPU until every channel is loaded
//   done      - all channels loaded
//   error     - header count exceeded DEPTH_WORDS
//   cur_chan  - channel being loaded (debug)
module prog_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH_WORDS  = 256,
    parameter int FILL_ZERO    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_valid,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            s_ready,
    output logic [ADDR_WIDTH-1:0]           w_addr,
    output logic [DATA_WIDTH-1:0]           w_dat,
    output logic [NUM_CHANNELS-1:0]         w_enb,
    output logic                            cpu_stall,
    output logic                            done,
    output logic                            error,
    output logic [$clog2(NUM_CHANNELS):0]   cur_chan
);
    localparam int IW = $clog2(DEPTH_WORDS) + 1;
    localparam int CW = $clog2(NUM_CHANNELS) + 1;

    generate
        if (DEPTH_WORDS * 4 > 2 ** ADDR_WIDTH || NUM_CHANNELS < 1) begin : g_bad_params
            $error("prog_loader: DEPTH_WORDS*4 must fit ADDR_WIDTH and NUM_CHANNELS must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, HEADER, LOAD, FILL, NEXT, DONE, ERROR} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   n, word_idx;
    logic [15:0]     hdr;
    logic            acc, can_start, last_word, last_chan, fill_end, do_fill;

    assign hdr       = s_data[15:0];
    assign acc       = s_valid & s_ready;
    assign can_start = start && (state == IDLE || state == DONE || state == ERROR);
    assign last_word = IW'(word_idx + 1'b1) == n;
    assign last_chan = cur_chan == CW'(NUM_CHANNELS - 1);
    assign fill_end  = word_idx == IW'(DEPTH_WORDS - 1);
    assign do_fill   = FILL_ZERO != 0 && n < IW'(DEPTH_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = can_start ? HEADER : IDLE;
            HEADER:  if (acc) state_nx = {16'd0, hdr} > 32'(DEPTH_WORDS) ? ERROR : hdr == 16'd0 ? NEXT : LOAD;
            LOAD:    if (acc && last_word) state_nx = do_fill ? FILL : NEXT;
            FILL:    state_nx = fill_end ? NEXT : FILL;
            NEXT:    state_nx = last_chan ? DONE : HEADER;
            DONE:    state_nx = can_start ? HEADER : DONE;
            ERROR:   state_nx = can_start ? HEADER : ERROR;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = state == HEADER || state == LOAD;
        done      = state == DONE;
        error     = state == ERROR;
        cpu_stall = state != DONE;
    end

    // Writes are registered: every accepted payload word or fill step shows up on w_* the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_chan <= '0;
            n        <= '0;
            word_idx <= '0;
            w_enb    <= '0;
            w_addr   <= '0;
            w_dat    <= '0;
        end else begin
            w_enb <= '0;
            if (can_start) cur_chan <= '0;
            if (state == NEXT && !last_chan) cur_chan <= cur_chan + 1'b1;
            if (state == HEADER && acc) begin
                n        <= IW'(hdr);
                word_idx <= '0;
            end
            if ((state == LOAD && acc) || state == FILL) begin
                w_enb    <= NUM_CHANNELS'(1) << cur_chan;
                w_addr   <= ADDR_WIDTH'({word_idx, 2'b00});
                w_dat    <= state == FILL ? '0 : s_data;
                word_idx <= word_idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Streaming boot loader for the rv32i_sc core.
- Accepts a word stream over a valid/ready handshake and writes it into NUM_CHANNELS BRAM write ports, in channel order. Channel 0 is the instruction BRAM and channel 1 is the data BRAM.
- Holds the CPU stalled until every channel is loaded, then releases it.
- Replaces the hand-driven BRAM write loops in benches; it is also the FPGA boot path on the Zybo Z7-20.

Parameters:
- DATA_WIDTH, 32, stream and BRAM data width.
- ADDR_WIDTH, 10, BRAM byte-address width (bram32 w_addr).
- NUM_CHANNELS, 2, number of BRAMs loaded in sequence (channel 0 first).
- DEPTH_WORDS, 256, maximum words per channel; must be <= 2^ADDR_WIDTH/4.
- FILL_ZERO, 0, when 1 each channel's unused words (N..DEPTH_WORDS-1) are written with 0 after its payload.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- s_valid, input, 1, stream word valid.
- s_data, input, DATA_WIDTH, stream word.
- s_ready, output, 1, loader accepts s_data this cycle.
- w_addr, output, ADDR_WIDTH, byte address for the active channel (word_index*4).
- w_dat, output, DATA_WIDTH, write data, shared by all channels.
- w_enb, output, NUM_CHANNELS, one-hot write enable; bit c selects channel c.
- cpu_stall, output, 1, drives pc stall; 1 while not loaded.
- done, output, 1, sticky, all channels loaded.
- error, output, 1, sticky, header rejected.
- cur_chan, output, clog2(NUM_CHANNELS)+1, channel being loaded (debug).

Behaviour:
- Reset (rst=0, async): state IDLE. Outputs: s_ready=0, w_enb=0, w_addr=0, w_dat=0, cpu_stall=1, done=0, error=0, cur_chan=0.
- Handshake: a word is accepted when s_valid & s_ready on a rising edge. s_ready is combinational from state only, never from s_valid. s_data is ignored when s_ready=0.
- Stream format: for each channel in order, one header word followed by N payload words. N = header[15:0]; header[31:16] is ignored.
- State IDLE: s_ready=0. On start: cur_chan=0 and go to HEADER.
- State HEADER: s_ready=1. On an accepted word:
  - N > DEPTH_WORDS: go to ERROR.
  - N == 0: go to NEXT.
  - Otherwise: latch N, clear word_idx, go to LOAD.
- State LOAD: s_ready=1. Each accepted word produces a registered write on the next cycle: w_enb[cur_chan]=1, w_addr=word_idx*4, w_dat=word. word_idx then increments.
  - Write latency is exactly 1 cycle after acceptance. Back-to-back accepts give back-to-back writes.
  - w_enb is a single-cycle pulse per word; it is 0 on any cycle without a write.
  - After word N-1 is accepted: go to FILL if FILL_ZERO=1 and N < DEPTH_WORDS, else go to NEXT.
- State FILL: s_ready=0. Writes 0 to word_idx..DEPTH_WORDS-1, one word per cycle, on the current channel, then goes to NEXT.
- State NEXT (1 cycle): s_ready=0. If cur_chan == NUM_CHANNELS-1, go to DONE; else increment cur_chan and go to HEADER.
- State DONE: done=1, cpu_stall=0, s_ready=0. On start: done=0, cpu_stall=1, go to HEADER with cur_chan=0.
- State ERROR: error=1, cpu_stall=1, s_ready=0. No writes. Only start or reset exits.
  - On start: error=0, go to HEADER with cur_chan=0.
- start outside IDLE/DONE/ERROR is ignored; no state or counter change.
- Reset mid-load: state and all outputs return to reset values immediately. A write pending in the output register is dropped (w_enb=0).
- word_idx width is clog2(DEPTH_WORDS)+1, so it never wraps for N == DEPTH_WORDS.
- w_addr is word_idx*4, truncated to ADDR_WIDTH.
- Elaboration: parameter violations (DEPTH_WORDS*4 > 2^ADDR_WIDTH, NUM_CHANNELS < 1) must fail elaboration.

Test Plan:
1. Basic load. Defaults. Stream: header 6, instructions I0..I5, header 3, data D0..D2, s_valid held high.
   - Required: w_enb[0] at addresses 0x0..0x14 with I0..I5, then w_enb[1] at 0x0..0x8 with D0..D2.
   - Each write occurs 1 cycle after its accept. done=1 and cpu_stall=0 after the last NEXT. Running a jalr program afterwards gives x5=0x0000000C and mem[0xC]=0x00000008.
2. Backpressure/gaps. Same stream with s_valid toggling every other cycle.
   - Required: identical write sequence; no write on cycles without an accept; total write count = 9.
3. Oversize header. Channel 1 header 257.
   - Required: error=1, cpu_stall=1, s_ready=0, no channel 1 writes. A start then a valid stream completes with error=0 and done=1.
4. Zero count. Channel 0 header 0, channel 1 header 2.
   - Required: no w_enb[0]; two w_enb[1] writes at 0x0 and 0x4; done=1.
5. FILL_ZERO=1, DEPTH_WORDS=8. Channel 0 header 3 with A, B, C.
   - Required: writes at 0x0..0x8 with A, B, C, then 5 writes of 0x00000000 at 0xC..0x1C. s_ready=0 during the fill.
6. Reset/start misuse.
   - rst low for 1 cycle mid-LOAD: all outputs return to reset values asynchronously, with no further writes.
   - start during LOAD: ignored; the word count and addresses continue unchanged.
